// File: rtl/uart_rx_8n1.sv
// UART receiver for 8N1 frames.
// The rx pin is synchronised, then a start edge arms a timer. The start bit
// is re-checked at half a bit, and every later bit is sampled one full bit
// period after the previous sample. A good frame gives a one-cycle valid
// strobe. A low stop bit gives a one-cycle frame_err strobe, and the receiver
// then waits for the line to go high again.
module uart_rx_8n1 #(
  parameter int FREQ = 12000000,
  parameter int BAUD = 9600
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int LIM  = FREQ / BAUD;
  localparam int HALF = LIM / 2;

  localparam logic [10:0] LIM_END  = 11'(LIM - 1);
  localparam logic [10:0] HALF_END = 11'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state, state_n;
  logic        rx_m, rx_s;
  logic [10:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  data_n;
  logic        valid_n, err_n;

  // Two-flop synchroniser; reset to the idle (high) line level so a reset
  // never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic: decides when to sample and what each sample does.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 11'd1;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = 11'd0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n   = 11'd0;
          idx_n   = 3'd0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LIM_END) begin
          cnt_n   = 11'd0;
          shift_n = {rx_s, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LIM_END) begin
          cnt_n = 11'd0;
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_n = 11'd0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = 11'd0;
        state_n = IDLE;
      end
    endcase
  end

  // Datapath and strobe registers, updated from the next-state decisions.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt       <= 11'd0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= err_n;
    end
  end

  assign busy = (state != IDLE);

endmodule
